// File: rtl/screen_sequencer_if.sv
// Screen sequencer signal bundle.
// Groups the video timing, game-control and colour inputs together with the sequencer outputs.
//   master : drives video_on, pixel_y, start_sw, game_over and the three colour sources;
//            observes frame_tick, game_reset, game_active, state_dbg and vga_rgb.
//   slave  : the sequencer side (the reverse directions).
interface screen_sequencer_if;
  logic        video_on;
  logic [10:0] pixel_y;
  logic        start_sw;
  logic        game_over;
  logic [4:0]  title_rgb;
  logic [4:0]  game_rgb;
  logic [4:0]  over_rgb;
  logic [1:0]  frame_tick;
  logic        game_reset;
  logic        game_active;
  logic [1:0]  state_dbg;
  logic [4:0]  vga_rgb;

  modport master (
    output video_on, pixel_y, start_sw, game_over, title_rgb, game_rgb, over_rgb,
    input  frame_tick, game_reset, game_active, state_dbg, vga_rgb
  );

  modport slave (
    input  video_on, pixel_y, start_sw, game_over, title_rgb, game_rgb, over_rgb,
    output frame_tick, game_reset, game_active, state_dbg, vga_rgb
  );
endinterface

// File: rtl/screen_sequencer.sv
// Top-level screen state machine for the display path: TITLE -> START_WAIT -> PLAYING ->
// GAME_OVER -> TITLE. Produces the title flicker phase, debounces the start switch on frame
// boundaries and registers the selected colour source onto vga_rgb.
// Ports:
//   clk      system clock
//   reset_n  synchronous active-low reset
//   bus      screen_sequencer_if.slave: video_on, pixel_y, start_sw, game_over, title_rgb,
//            game_rgb, over_rgb in; frame_tick, game_reset, game_active, state_dbg, vga_rgb out
module screen_sequencer #(
  parameter int unsigned SCREEN_H        = 480,
  parameter int unsigned FLICK_FRAMES    = 15,
  parameter int unsigned DEBOUNCE_FRAMES = 4,
  parameter int unsigned GAMEOVER_FRAMES = 180
) (
  input  logic                clk,
  input  logic                reset_n,
  screen_sequencer_if.slave   bus
);

  localparam logic [1:0] StTitle     = 2'd0;
  localparam logic [1:0] StStartWait = 2'd1;
  localparam logic [1:0] StPlaying   = 2'd2;
  localparam logic [1:0] StGameOver  = 2'd3;

  localparam logic [10:0] LineEnd   = 11'(SCREEN_H);
  localparam logic [7:0]  FlickLast = 8'(FLICK_FRAMES - 1);
  localparam logic [3:0]  DebLast   = 4'(DEBOUNCE_FRAMES - 1);
  localparam logic [7:0]  OverLast  = 8'(GAMEOVER_FRAMES - 1);

  logic [1:0]  state_q, state_d;
  logic [10:0] pixel_y_q;
  logic [7:0]  flick_q, flick_d;
  logic [1:0]  tick_q, tick_d;
  logic [3:0]  deb_q, deb_d;
  logic [7:0]  over_q, over_d;
  logic        armed_q, armed_d;
  logic        game_reset_q, game_active_q;
  logic [4:0]  rgb_q, rgb_d;
  logic        frame_pulse;

  // Rising edge of "line == SCREEN_H": one pulse per frame however long the line lasts.
  assign frame_pulse = (bus.pixel_y == LineEnd) && (pixel_y_q != LineEnd);

  always_comb begin
    state_d = state_q;
    flick_d = flick_q;
    tick_d  = tick_q;
    deb_d   = deb_q;
    over_d  = over_q;
    armed_d = armed_q;

    // Flicker runs only on the title screens and is frozen during play.
    if ((state_q == StTitle || state_q == StStartWait) && frame_pulse) begin
      if (flick_q == FlickLast) begin
        flick_d = '0;
        tick_d  = tick_q + 2'd1;
      end else begin
        flick_d = flick_q + 8'd1;
      end
    end

    case (state_q)
      StTitle: begin
        // A switch left high must be seen low on a frame boundary before it can start a game.
        if (frame_pulse && !bus.start_sw) armed_d = 1'b1;
        if (armed_q && bus.start_sw) begin
          state_d = StStartWait;
          deb_d   = '0;
        end
      end
      StStartWait: begin
        if (!bus.start_sw) begin
          state_d = StTitle;
          deb_d   = '0;
          armed_d = 1'b1;
        end else if (frame_pulse) begin
          if (deb_q == DebLast) begin
            state_d = StPlaying;
            deb_d   = '0;
          end else begin
            deb_d = deb_q + 4'd1;
          end
        end
      end
      StPlaying: begin
        if (bus.game_over) begin
          state_d = StGameOver;
          over_d  = '0;
        end
      end
      StGameOver: begin
        if (frame_pulse) begin
          if (over_q == OverLast) begin
            state_d = StTitle;
            over_d  = '0;
            armed_d = 1'b0;
          end else begin
            over_d = over_q + 8'd1;
          end
        end
      end
      default: ;
    endcase

    if (state_d == StTitle && state_q != StTitle) flick_d = '0;
  end

  always_comb begin
    rgb_d = '0;
    if (bus.video_on) begin
      case (state_q)
        StTitle, StStartWait: rgb_d = bus.title_rgb;
        StPlaying:            rgb_d = bus.game_rgb;
        default:              rgb_d = bus.over_rgb;
      endcase
    end
  end

  // Previous line is tracked through reset so a held SCREEN_H line never fakes a boundary.
  always_ff @(posedge clk) begin
    pixel_y_q <= bus.pixel_y;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= StTitle;
      flick_q       <= '0;
      tick_q        <= '0;
      deb_q         <= '0;
      over_q        <= '0;
      armed_q       <= 1'b0;
      game_reset_q  <= 1'b0;
      game_active_q <= 1'b0;
      rgb_q         <= '0;
    end else begin
      state_q       <= state_d;
      flick_q       <= flick_d;
      tick_q        <= tick_d;
      deb_q         <= deb_d;
      over_q        <= over_d;
      armed_q       <= armed_d;
      game_reset_q  <= (state_d == StPlaying) && (state_q != StPlaying);
      game_active_q <= (state_d == StPlaying);
      rgb_q         <= rgb_d;
    end
  end

  assign bus.frame_tick  = tick_q;
  assign bus.game_reset  = game_reset_q;
  assign bus.game_active = game_active_q;
  assign bus.state_dbg   = state_q;
  assign bus.vga_rgb     = rgb_q;

endmodule

// File: tb/tb_screen_sequencer.sv
// Self-checking bench for screen_sequencer. A behavioural model tracks screens, frame counts
// and the flicker phase arithmetically from the input stream; scenario tasks compare inline.
module tb_screen_sequencer;
  localparam int H  = 480;
  localparam int FL = 15;
  localparam int DB = 4;
  localparam int GO = 180;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  screen_sequencer_if bus();

  screen_sequencer #(
    .SCREEN_H(H), .FLICK_FRAMES(FL), .DEBOUNCE_FRAMES(DB), .GAMEOVER_FRAMES(GO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // stimulus state
  int run_left = 0;
  bit rand_rgb = 1'b1;

  // model state
  int m_mode = 0, m_prev_y = 0, m_pulses = 0;
  int m_title_p = 0, m_tick_base = 0, m_hi = 0;
  bit m_armed = 1'b0, m_greset = 1'b0;
  logic [4:0] m_rgb = '0;

  function automatic int exp_tick();
    return (m_tick_base + m_title_p / FL) % 4;
  endfunction

  function automatic void enter_title();
    m_tick_base = exp_tick();
    m_title_p   = 0;
    m_mode      = 0;
  endfunction

  int m_over = 0;

  function automatic void model_update();
    bit pulse;
    int old_mode;
    pulse = (int'(bus.pixel_y) == H) && (m_prev_y != H);
    m_prev_y = int'(bus.pixel_y);
    if (pulse) m_pulses++;
    old_mode = m_mode;
    if (!reset_n) begin
      m_mode = 0; m_title_p = 0; m_tick_base = 0; m_hi = 0; m_over = 0;
      m_armed = 0; m_greset = 0; m_rgb = '0;
      return;
    end
    if (!bus.video_on) m_rgb = '0;
    else if (m_mode < 2) m_rgb = bus.title_rgb;
    else if (m_mode == 2) m_rgb = bus.game_rgb;
    else m_rgb = bus.over_rgb;
    if (m_mode < 2 && pulse) m_title_p++;
    case (m_mode)
      0: begin
        if (m_armed && bus.start_sw) begin m_mode = 1; m_hi = 0; end
        else if (pulse && !bus.start_sw) m_armed = 1;
      end
      1: begin
        if (!bus.start_sw) begin m_hi = 0; m_armed = 1; enter_title(); end
        else if (pulse) begin
          m_hi++;
          if (m_hi == DB) begin m_mode = 2; m_hi = 0; end
        end
      end
      2: if (bus.game_over) begin m_mode = 3; m_over = 0; end
      default: if (pulse) begin
        m_over++;
        if (m_over == GO) begin m_over = 0; m_armed = 0; enter_title(); end
      end
    endcase
    m_greset = (old_mode == 1 && m_mode == 2);
  endfunction

  task automatic next_pixel();
    if (run_left == 0) begin
      if (int'(bus.pixel_y) == H) begin
        bus.pixel_y = 11'($urandom_range(0, H - 1));
        run_left = $urandom_range(1, 4);
      end else begin
        bus.pixel_y = 11'(H);
        run_left = $urandom_range(1, 3);
      end
    end
    run_left--;
    if (rand_rgb) begin
      bus.title_rgb = 5'($urandom_range(1, 31));
      bus.game_rgb  = 5'($urandom_range(1, 31));
      bus.over_rgb  = 5'($urandom_range(1, 31));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    next_pixel();
  endtask

  task automatic test_reset();
    bus.start_sw = 1'b1;
    reset_n = 1'b0;
    repeat (4) step();
    checks += 5;
    if (bus.state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", bus.state_dbg); end
    if (bus.frame_tick !== 2'd0) begin errors++; $display("FAIL reset_tick got %0d want 0", bus.frame_tick); end
    if (bus.vga_rgb !== 5'd0) begin errors++; $display("FAIL reset_rgb got %0h want 0", bus.vga_rgb); end
    if (bus.game_active !== 1'b0) begin errors++; $display("FAIL reset_active got %0b want 0", bus.game_active); end
    if (bus.game_reset !== 1'b0) begin errors++; $display("FAIL reset_greset got %0b want 0", bus.game_reset); end
    reset_n = 1'b1;
  endtask

  task automatic test_stuck_high();
    int p0 = m_pulses;
    int guard = 0;
    bus.start_sw = 1'b1;
    while (m_pulses - p0 < 20 && guard < 400) begin
      step(); guard++;
      checks++;
      if (bus.state_dbg !== 2'd0) begin errors++; $display("FAIL stuck_high_state got %0d want 0", bus.state_dbg); end
    end
    checks++;
    if (m_pulses - p0 < 20) begin errors++; $display("FAIL stuck_high_frames got %0d want 20", m_pulses - p0); end
  endtask

  task automatic test_flicker();
    int p0, n, guard;
    reset_n = 1'b0; step(); reset_n = 1'b1;
    bus.start_sw = 1'b0;
    p0 = m_pulses; guard = 0;
    while (m_pulses - p0 < 60 && guard < 1000) begin
      step(); guard++;
      n = m_pulses - p0;
      checks += 2;
      if (bus.frame_tick !== 2'((n / FL) % 4)) begin
        errors++; $display("FAIL flicker_tick pulses %0d got %0d want %0d", n, bus.frame_tick, (n / FL) % 4);
      end
      if (bus.state_dbg !== 2'd0) begin errors++; $display("FAIL flicker_state got %0d want 0", bus.state_dbg); end
    end
    checks++;
    if (bus.frame_tick !== 2'd0 || n != 60) begin errors++; $display("FAIL flicker_wrap got %0d want 0", bus.frame_tick); end
    rand_rgb = 1'b0;
    bus.title_rgb = 5'b00111; bus.video_on = 1'b1;
    step();
    checks++;
    if (bus.vga_rgb !== 5'b00111) begin errors++; $display("FAIL title_rgb got %0h want 07", bus.vga_rgb); end
    rand_rgb = 1'b1;
  endtask

  task automatic test_debounce();
    int p0, guard, resets;
    bus.start_sw = 1'b0;
    p0 = m_pulses; guard = 0;
    while (m_pulses - p0 < 1 && guard < 50) begin step(); guard++; end
    bus.start_sw = 1'b1;
    guard = 0;
    while (m_hi < 3 && guard < 200) begin
      step(); guard++;
      checks++;
      if (bus.state_dbg !== 2'(m_mode)) begin errors++; $display("FAIL deb1_state got %0d want %0d", bus.state_dbg, m_mode); end
    end
    checks++;
    if (bus.state_dbg !== 2'd1) begin errors++; $display("FAIL deb1_wait got %0d want 1", bus.state_dbg); end
    bus.start_sw = 1'b0;
    step();
    checks++;
    if (bus.state_dbg !== 2'd0) begin errors++; $display("FAIL deb1_abort got %0d want 0", bus.state_dbg); end
    bus.start_sw = 1'b1;
    guard = 0; resets = 0;
    while (guard < 40) begin
      step(); guard++;
      if (bus.game_reset === 1'b1) resets++;
      checks += 3;
      if (bus.state_dbg !== 2'(m_mode)) begin errors++; $display("FAIL deb2_state got %0d want %0d", bus.state_dbg, m_mode); end
      if (bus.game_reset !== m_greset) begin errors++; $display("FAIL deb2_greset got %0b want %0b", bus.game_reset, m_greset); end
      if (bus.game_active !== (m_mode == 2)) begin errors++; $display("FAIL deb2_active got %0b want %0b", bus.game_active, m_mode == 2); end
      if (m_mode == 2) bus.start_sw = 1'($urandom);
    end
    checks += 2;
    if (resets != 1) begin errors++; $display("FAIL deb2_greset_count got %0d want 1", resets); end
    if (bus.game_active !== 1'b1) begin errors++; $display("FAIL deb2_playing got %0b want 1", bus.game_active); end
  endtask

  task automatic test_reset_mid_play();
    bus.video_on = 1'b1;
    reset_n = 1'b0; step(); reset_n = 1'b1;
    checks += 4;
    if (bus.state_dbg !== 2'd0) begin errors++; $display("FAIL midreset_state got %0d want 0", bus.state_dbg); end
    if (bus.frame_tick !== 2'd0) begin errors++; $display("FAIL midreset_tick got %0d want 0", bus.frame_tick); end
    if (bus.vga_rgb !== 5'd0) begin errors++; $display("FAIL midreset_rgb got %0h want 0", bus.vga_rgb); end
    if (bus.game_active !== 1'b0) begin errors++; $display("FAIL midreset_active got %0b want 0", bus.game_active); end
  endtask

  task automatic goto_playing();
    int guard = 0;
    bus.start_sw = 1'b0;
    while (!m_armed && guard < 100) begin step(); guard++; end
    bus.start_sw = 1'b1;
    while (m_mode != 2 && guard < 600) begin step(); guard++; end
    checks++;
    if (bus.state_dbg !== 2'd2) begin errors++; $display("FAIL goto_playing got %0d want 2", bus.state_dbg); end
  endtask

  task automatic test_game_over();
    int p0, guard;
    guard = 0;
    while (!(int'(bus.pixel_y) == H && m_prev_y != H) && guard < 20) begin step(); guard++; end
    bus.game_over = 1'b1;
    step();
    bus.game_over = 1'b0;
    checks++;
    if (bus.state_dbg !== 2'd3) begin errors++; $display("FAIL over_entry got %0d want 3", bus.state_dbg); end
    p0 = m_pulses; guard = 0;
    while (bus.state_dbg === 2'd3 && guard < 3000) begin
      bus.game_over = ($urandom_range(0, 9) == 0);
      bus.video_on = ($urandom_range(0, 7) != 0);
      step(); guard++;
      checks += 2;
      if (bus.state_dbg !== 2'(m_mode)) begin errors++; $display("FAIL over_state got %0d want %0d", bus.state_dbg, m_mode); end
      if (bus.vga_rgb !== m_rgb) begin errors++; $display("FAIL over_rgb got %0h want %0h", bus.vga_rgb, m_rgb); end
    end
    bus.game_over = 1'b0; bus.video_on = 1'b1;
    checks += 2;
    if (m_pulses - p0 != GO) begin errors++; $display("FAIL over_frames got %0d want %0d", m_pulses - p0, GO); end
    if (bus.state_dbg !== 2'd0) begin errors++; $display("FAIL over_exit got %0d want 0", bus.state_dbg); end
  endtask

  task automatic test_video_off();
    logic [3:0] seen = '0;
    int guard = 0;
    bus.video_on = 1'b0;
    while (seen != 4'hF && guard < 4000) begin
      bus.game_over = 1'b0;
      case (m_mode)
        0: bus.start_sw = m_armed;
        1: bus.start_sw = 1'b1;
        2: bus.game_over = ($urandom_range(0, 5) == 0);
        default: ;
      endcase
      step(); guard++;
      seen[bus.state_dbg] = 1'b1;
      checks++;
      if (bus.vga_rgb !== 5'd0) begin errors++; $display("FAIL video_off_rgb state %0d got %0h want 0", bus.state_dbg, bus.vga_rgb); end
    end
    checks++;
    if (seen != 4'hF) begin errors++; $display("FAIL video_off_states got %0h want f", seen); end
    bus.video_on = 1'b1; bus.game_over = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 39) == 0) bus.start_sw = ~bus.start_sw;
      bus.game_over = ($urandom_range(0, 29) == 0);
      bus.video_on  = ($urandom_range(0, 7) != 0);
      reset_n       = ($urandom_range(0, 499) != 0);
      step();
      checks += 5;
      if (bus.state_dbg !== 2'(m_mode)) begin errors++; $display("FAIL rnd_state got %0d want %0d", bus.state_dbg, m_mode); end
      if (bus.frame_tick !== 2'(exp_tick())) begin errors++; $display("FAIL rnd_tick got %0d want %0d", bus.frame_tick, exp_tick()); end
      if (bus.vga_rgb !== m_rgb) begin errors++; $display("FAIL rnd_rgb got %0h want %0h", bus.vga_rgb, m_rgb); end
      if (bus.game_reset !== m_greset) begin errors++; $display("FAIL rnd_greset got %0b want %0b", bus.game_reset, m_greset); end
      if (bus.game_active !== (m_mode == 2)) begin errors++; $display("FAIL rnd_active got %0b want %0b", bus.game_active, m_mode == 2); end
    end
    reset_n = 1'b1;
  endtask

  initial begin
    bus.video_on = 1'b1;
    bus.pixel_y = 11'd0;
    bus.start_sw = 1'b1;
    bus.game_over = 1'b0;
    bus.title_rgb = 5'd1;
    bus.game_rgb = 5'd2;
    bus.over_rgb = 5'd3;
    test_reset();
    test_stuck_high();
    test_flicker();
    test_debounce();
    test_reset_mid_play();
    goto_playing();
    test_game_over();
    test_video_off();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
